psum_accumulator: RTL and testbench

//  Downstream stage of the 16-input adder tree. Accumulates the tree's per-tile partial sums
//  (one per input-channel tile) into one output-pixel value, adds a per-pixel bias, applies

---
 rtl/cnn_pkg.sv | 29 ++
 rtl/sat_relu_unit.sv | 21 ++
 rtl/psum_accumulator.sv | 113 +++++++++++
 tb/tb_psum_accumulator.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared CNN datapath definitions: widths, accumulator FSM states and the
// signed saturation helper used by the accumulator and pooling stages.
package cnn_pkg;

    localparam int DWIDTH     = 16;
    localparam int ACC_WIDTH  = 24;
    localparam int MAX_TILES  = 64;
    localparam int TILE_CNT_W = $clog2(MAX_TILES + 1);

    typedef enum logic {S_IDLE, S_ACC} acc_state_e;

    localparam logic signed [ACC_WIDTH-1:0] SAT_HI =
        {{(ACC_WIDTH-DWIDTH+1){1'b0}}, {(DWIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_LO =
        {{(ACC_WIDTH-DWIDTH+1){1'b1}}, {(DWIDTH-1){1'b0}}};

    function automatic logic signed [DWIDTH-1:0] sat_signed(input logic signed [ACC_WIDTH-1:0] value);
        logic signed [DWIDTH-1:0] result;
        if (value > SAT_HI) begin
            result = {1'b0, {(DWIDTH-1){1'b1}}};
        end else if (value < SAT_LO) begin
            result = {1'b1, {(DWIDTH-1){1'b0}}};
        end else begin
            result = value[DWIDTH-1:0];
        end
        return result;
    endfunction

endpackage

// File: rtl/sat_relu_unit.sv
// Combinational optional ReLU followed by signed saturation from the
// accumulator width down to the feature-map data width.
module sat_relu_unit
    import cnn_pkg::*;
(
    input  logic signed [ACC_WIDTH-1:0] value,
    input  logic                        relu_en,
    output logic signed [DWIDTH-1:0]    result
);

    logic signed [ACC_WIDTH-1:0] rectified;

    always_comb begin
        rectified = value;
        if (relu_en && value[ACC_WIDTH-1]) begin
            rectified = '0;
        end
        result = sat_signed(rectified);
    end

endmodule

// File: rtl/psum_accumulator.sv
// Accumulates per-tile partial sums into one biased, optionally rectified and
// saturated output pixel, delivered over a valid/ready stream.
module psum_accumulator
    import cnn_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clear,
    input  logic [TILE_CNT_W-1:0]        cfg_num_tiles,
    input  logic                         cfg_relu_en,
    input  logic signed [DWIDTH-1:0]     bias_in,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [DWIDTH-1:0]     psum_in,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [DWIDTH-1:0]     out_data,
    output logic                         busy
);

    acc_state_e                  state, state_next;
    logic signed [ACC_WIDTH-1:0] acc, acc_base, acc_sum, psum_ext;
    logic [TILE_CNT_W-1:0]       tile_cnt, num_tiles_q, cfg_tiles_eff;
    logic                        relu_q, relu_sel, last_slot, beat;
    logic signed [DWIDTH-1:0]    result;

    // Zero tiles degenerates to a single-tile pixel; oversize counts clamp.
    always_comb begin
        cfg_tiles_eff = cfg_num_tiles;
        if (cfg_num_tiles == '0) begin
            cfg_tiles_eff = TILE_CNT_W'(1);
        end else if (cfg_num_tiles > TILE_CNT_W'(MAX_TILES)) begin
            cfg_tiles_eff = TILE_CNT_W'(MAX_TILES);
        end
    end

    always_comb begin
        state_next = state;
        last_slot  = 1'b0;
        acc_base   = acc;
        relu_sel   = relu_q;
        psum_ext   = {{(ACC_WIDTH-DWIDTH){psum_in[DWIDTH-1]}}, psum_in};
        if (state == S_IDLE) begin
            last_slot = (cfg_tiles_eff == TILE_CNT_W'(1));
            acc_base  = {{(ACC_WIDTH-DWIDTH){bias_in[DWIDTH-1]}}, bias_in};
            relu_sel  = cfg_relu_en;
        end else begin
            last_slot = (tile_cnt == num_tiles_q - TILE_CNT_W'(1));
        end
        acc_sum  = acc_base + psum_ext;
        in_ready = !clear && (!last_slot || !out_valid || out_ready);
        beat     = in_valid && in_ready;
        if (clear) begin
            state_next = S_IDLE;
        end else if (beat) begin
            state_next = last_slot ? S_IDLE : S_ACC;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc         <= '0;
            tile_cnt    <= '0;
            num_tiles_q <= '0;
            relu_q      <= 1'b0;
        end else if (clear) begin
            acc      <= '0;
            tile_cnt <= '0;
        end else if (beat) begin
            if (last_slot) begin
                acc      <= '0;
                tile_cnt <= '0;
            end else begin
                acc      <= acc_sum;
                tile_cnt <= tile_cnt + TILE_CNT_W'(1);
            end
            if (state == S_IDLE) begin
                num_tiles_q <= cfg_tiles_eff;
                relu_q      <= cfg_relu_en;
            end
        end
    end

    sat_relu_unit u_sat_relu (
        .value   (acc_sum),
        .relu_en (relu_sel),
        .result  (result)
    );

    // A final beat may only land when the output register is free or draining.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (beat && last_slot) begin
            out_valid <= 1'b1;
            out_data  <= result;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign busy = (state == S_ACC);

endmodule

// File: tb/tb_psum_accumulator.sv
// Scoreboard bench for psum_accumulator: directed corner cases plus
// randomized pixels checked against a plain-arithmetic reference model.
module tb_psum_accumulator;

    logic              clk;
    logic              rst_n;
    logic              clear;
    logic [6:0]        cfg_num_tiles;
    logic              cfg_relu_en;
    logic signed [15:0] bias_in;
    logic              in_valid;
    logic              in_ready;
    logic signed [15:0] psum_in;
    logic              out_valid;
    logic              out_ready;
    logic signed [15:0] out_data;
    logic              busy;

    int total = 0;
    int bad   = 0;
    int sb[$];
    int psum_list[$];
    int ready_mode = 1;
    int cyc = 0;
    bit holding = 0;
    int held = 0;

    psum_accumulator dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .clear         (clear),
        .cfg_num_tiles (cfg_num_tiles),
        .cfg_relu_en   (cfg_relu_en),
        .bias_in       (bias_in),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .psum_in       (psum_in),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .busy          (busy)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    // Consumer back-pressure: 0 = stall, 1 = always ready, 2 = random.
    initial begin
        out_ready = 1;
        forever begin
            @(posedge clk);
            #2;
            case (ready_mode)
                0:       out_ready = 0;
                1:       out_ready = 1;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic check_output(input string name, input int actual, input int expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, want %0d", name, actual, expected);
        end
    endtask

    function automatic int eff_tiles(input int cfg);
        if (cfg == 0) return 1;
        if (cfg > 64) return 64;
        return cfg;
    endfunction

    function automatic int model_pixel(input int bias, input bit relu);
        longint s = bias;
        foreach (psum_list[i]) s += psum_list[i];
        if (relu && s < 0) s = 0;
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
        return int'(s);
    endfunction

    // Monitor: pops an expectation on each output handshake, checks holds.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (holding) check_output("hold_stable", int'(out_data), held);
            if (out_ready) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected_pixel: got %0d, want none", int'(out_data));
                end else begin
                    check_output("pixel", int'(out_data), sb.pop_front());
                end
                holding = 0;
            end else begin
                holding = 1;
                held    = int'(out_data);
            end
        end else begin
            holding = 0;
        end
    end

    task automatic drive_beat(input int p, input int tiles_cfg, input bit relu, input int bias,
                              output int waits);
        in_valid      = 1;
        psum_in       = 16'(p);
        cfg_num_tiles = 7'(tiles_cfg);
        cfg_relu_en   = relu;
        bias_in       = 16'(bias);
        waits         = 0;
        forever begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                in_valid = 0;
                return;
            end
            waits++;
            if (waits > 200) begin
                check_output("beat_timeout", waits, 0);
                in_valid = 0;
                return;
            end
            @(posedge clk);
            #1;
        end
    endtask

    // Issues one pixel from psum_list; config is scrambled after the first beat.
    task automatic apply_stimulus(input int tiles_cfg, input bit relu, input int bias,
                                  input bit gaps, output int stalls);
        int w;
        stalls = 0;
        sb.push_back(model_pixel(bias, relu));
        foreach (psum_list[i]) begin
            if (i == 0) drive_beat(psum_list[i], tiles_cfg, relu, bias, w);
            else drive_beat(psum_list[i], int'($urandom_range(0, 127)), 1'($urandom_range(0, 1)),
                            int'($urandom_range(0, 65535)) - 32768, w);
            stalls += w;
            if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        int st, w, c0;
        rst_n = 0; clear = 0; in_valid = 0; psum_in = 0;
        cfg_num_tiles = 0; cfg_relu_en = 0; bias_in = 0;
        repeat (3) @(negedge clk);
        check_output("reset_out_valid", int'(out_valid), 0);
        check_output("reset_out_data", int'(out_data), 0);
        check_output("reset_busy", int'(busy), 0);
        @(posedge clk); #1;
        rst_n = 1;
        wait_cycles(1);

        $display("[TB] basic accumulation");
        psum_list = '{100, 200, -50, 5};
        apply_stimulus(4, 0, 10, 0, st);
        check_output("latency_out_valid", int'(out_valid), 1);
        check_output("latency_out_data", int'(out_data), 265);

        $display("[TB] saturation and relu");
        psum_list = '{30000, 30000};   apply_stimulus(2, 0, 0, 0, st);
        psum_list = '{-30000, -30000}; apply_stimulus(2, 0, 0, 0, st);
        psum_list = '{3};              apply_stimulus(1, 1, -5, 0, st);
        psum_list = '{3};              apply_stimulus(1, 0, -5, 0, st);
        psum_list = '{3};              apply_stimulus(0, 0, -5, 0, st);
        wait_cycles(3);

        $display("[TB] output back-pressure");
        ready_mode = 0;
        wait_cycles(1);
        psum_list = '{8};
        apply_stimulus(1, 0, 7, 0, st);
        psum_list = '{5, 6, 7};
        sb.push_back(model_pixel(-20, 0));
        drive_beat(5, 3, 0, -20, w);
        check_output("stall_beat1_waits", w, 0);
        drive_beat(6, 0, 1, 999, w);
        check_output("stall_beat2_waits", w, 0);
        check_output("stall_busy", int'(busy), 1);
        in_valid = 1; psum_in = 7;
        repeat (3) begin
            @(negedge clk);
            check_output("stall_last_in_ready", int'(in_ready), 0);
            @(posedge clk); #1;
        end
        ready_mode = 1;
        drive_beat(7, 0, 1, 999, w);
        wait_cycles(3);

        $display("[TB] clear");
        drive_beat(9, 4, 0, 50, w);
        drive_beat(9, 4, 0, 50, w);
        check_output("pre_clear_busy", int'(busy), 1);
        clear = 1; in_valid = 1; psum_in = 1000;
        @(negedge clk);
        check_output("clear_in_ready", int'(in_ready), 0);
        @(posedge clk); #1;
        clear = 0; in_valid = 0;
        check_output("post_clear_busy", int'(busy), 0);
        psum_list = '{1, 1, 1, 1};
        apply_stimulus(4, 0, 1, 0, st);
        wait_cycles(3);

        $display("[TB] async reset mid-pixel");
        ready_mode = 0;
        wait_cycles(1);
        psum_list = '{40};
        apply_stimulus(1, 0, 2, 0, st);
        drive_beat(3, 4, 0, 0, w);
        drive_beat(3, 4, 0, 0, w);
        #2;
        rst_n = 0;
        #1;
        check_output("async_rst_out_valid", int'(out_valid), 0);
        check_output("async_rst_out_data", int'(out_data), 0);
        check_output("async_rst_busy", int'(busy), 0);
        sb.delete();
        @(posedge clk); #1;
        rst_n = 1;
        ready_mode = 1;
        wait_cycles(2);

        $display("[TB] back-to-back throughput");
        c0 = cyc;
        w  = 0;
        repeat (4) begin
            psum_list.delete();
            repeat (3) psum_list.push_back(int'($urandom_range(0, 2000)) - 1000);
            apply_stimulus(3, 0, 17, 0, st);
            w += st;
        end
        check_output("throughput_stalls", w, 0);
        check_output("throughput_cycles", cyc - c0, 12);

        $display("[TB] randomized pixels");
        ready_mode = 2;
        for (int k = 0; k < 40; k++) begin
            int tc, n, b;
            bit r;
            tc = (k % 8 == 0) ? int'($urandom_range(0, 90)) : int'($urandom_range(0, 8));
            n  = eff_tiles(tc);
            r  = 1'($urandom_range(0, 1));
            b  = int'($urandom_range(0, 65535)) - 32768;
            psum_list.delete();
            for (int i = 0; i < n; i++) psum_list.push_back(int'($urandom_range(0, 65535)) - 32768);
            apply_stimulus(tc, r, b, 1'($urandom_range(0, 1)), st);
        end

        ready_mode = 1;
        for (int i = 0; i < 500 && sb.size() != 0; i++) @(posedge clk);
        check_output("drain_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
